fifo_read_packer: RTL and testbench

- Downstream consumer of the FIFO host stage.
- Issues single-beat read requests while the FIFO reports non-empty, and captures each returned word on `valid`.
- Packs PACK_WORDS consecutive words into one wide beat, then presents that beat on a valid/ready output handshake.
- Counts reads that return no data. This happens when the empty flag is stale or the FIFO was force-cleared, which is the observable symptom the host testbenches check for.

---
 rtl/fifo_pack_pkg.sv | 21 ++
 rtl/pack_buffer.sv | 31 +++
 rtl/fifo_read_packer.sv | 121 ++++++++++++
 tb/tb_fifo_read_packer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pack_pkg.sv
// Shared types and helpers for the FIFO read packer: FSM state encoding,
// slot-index width and saturating increment.
package fifo_pack_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        OUT
    } state_t;

    function automatic int unsigned idx_width(input int unsigned words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

endpackage

// File: rtl/pack_buffer.sv
// Word slot array for the packer: single-slot write, synchronous clear,
// flat view with slot 0 in the LSBs.
module pack_buffer import fifo_pack_pkg::*; #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned PACK_WORDS = 2,
    parameter int unsigned IDX_W      = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wr_en_i,
    input  logic [IDX_W-1:0]                 wr_idx_i,
    input  logic [DATA_WIDTH-1:0]            wr_data_i,
    input  logic                             clr_i,
    output logic [DATA_WIDTH*PACK_WORDS-1:0] data_o
);

    logic [PACK_WORDS-1:0][DATA_WIDTH-1:0] mem_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else if (clr_i) begin
            mem_q <= '0;
        end else if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign data_o = mem_q;

endmodule

// File: rtl/fifo_read_packer.sv
// Reads single words from the FIFO host stage one at a time, packs
// PACK_WORDS of them into a wide beat and counts reads that return nothing.
module fifo_read_packer import fifo_pack_pkg::*; #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned PACK_WORDS = 2,
    parameter int unsigned MISS_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             enable,
    input  logic                             flush,
    input  logic                             fifo_empty,
    input  logic [DATA_WIDTH-1:0]            read_data,
    input  logic                             valid,
    output logic                             read_enable,
    output logic [DATA_WIDTH*PACK_WORDS-1:0] out_data,
    output logic [$clog2(PACK_WORDS):0]      out_count,
    output logic                             out_partial,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [MISS_WIDTH-1:0]            miss_count
);

    localparam int unsigned IDX_W = idx_width(PACK_WORDS);
    localparam int unsigned CNT_W = $clog2(PACK_WORDS) + 1;
    localparam logic [31:0] MISS_MAX = 32'((64'd1 << MISS_WIDTH) - 64'd1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACK_WORDS - 1);

    state_t                  state_q;
    logic [IDX_W-1:0]        idx_q;
    logic                    read_enable_q;
    logic                    out_valid_q;
    logic                    out_partial_q;
    logic [CNT_W-1:0]        out_count_q;
    logic [MISS_WIDTH-1:0]   miss_q;
    logic [MISS_WIDTH-1:0]   miss_d;
    logic                    buf_wr;
    logic                    buf_clr;

    assign miss_d  = MISS_WIDTH'(sat_inc(32'(miss_q), MISS_MAX));
    assign buf_wr  = (state_q == WAIT) && valid;
    assign buf_clr = out_valid_q && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            read_enable_q <= 1'b0;
            out_valid_q   <= 1'b0;
            out_partial_q <= 1'b0;
            out_count_q   <= '0;
            miss_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Flush wins over a new read so a partial beat is never delayed.
                    if (flush && (idx_q != '0)) begin
                        state_q       <= OUT;
                        out_valid_q   <= 1'b1;
                        out_count_q   <= CNT_W'(idx_q);
                        out_partial_q <= 1'b1;
                    end else if (enable && !fifo_empty) begin
                        state_q       <= REQ;
                        read_enable_q <= 1'b1;
                    end
                end
                REQ: begin
                    read_enable_q <= 1'b0;
                    state_q       <= WAIT;
                end
                WAIT: begin
                    if (valid) begin
                        if (idx_q == LAST_IDX) begin
                            state_q       <= OUT;
                            out_valid_q   <= 1'b1;
                            out_count_q   <= CNT_W'(PACK_WORDS);
                            out_partial_q <= 1'b0;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= IDLE;
                        end
                    end else begin
                        miss_q  <= miss_d;
                        state_q <= IDLE;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state_q       <= IDLE;
                        idx_q         <= '0;
                        out_valid_q   <= 1'b0;
                        out_count_q   <= '0;
                        out_partial_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    pack_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .PACK_WORDS (PACK_WORDS),
        .IDX_W      (IDX_W)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (buf_wr),
        .wr_idx_i  (idx_q),
        .wr_data_i (read_data),
        .clr_i     (buf_clr),
        .data_o    (out_data)
    );

    assign read_enable = read_enable_q;
    assign out_valid   = out_valid_q;
    assign out_partial = out_partial_q;
    assign out_count   = out_count_q;
    assign miss_count  = miss_q;

endmodule

// File: tb/tb_fifo_read_packer.sv
// Scoreboard bench for fifo_read_packer: behavioural FIFO model, expected
// beats queued when words are supplied and compared on each handshake.
module tb_fifo_read_packer;

    localparam int unsigned DW = 12;
    localparam int unsigned PW = 2;
    localparam int unsigned MW = 8;

    typedef struct {
        logic [DW*PW-1:0] data;
        int unsigned      cnt;
        logic             partial;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic              flush = 1'b0;
    logic              fifo_empty = 1'b1;
    logic [DW-1:0]     read_data = '0;
    logic              valid = 1'b0;
    logic              read_enable;
    logic [DW*PW-1:0]  out_data;
    logic [$clog2(PW):0] out_count;
    logic              out_partial;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [MW-1:0]     miss_count;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned beats = 0;
    int unsigned re_cnt = 0;
    logic        stale = 1'b0;
    logic [DW-1:0] fq[$];
    beat_t       exp_q[$];

    fifo_read_packer #(
        .DATA_WIDTH (DW),
        .PACK_WORDS (PW),
        .MISS_WIDTH (MW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .flush       (flush),
        .fifo_empty  (fifo_empty),
        .read_data   (read_data),
        .valid       (valid),
        .read_enable (read_enable),
        .out_data    (out_data),
        .out_count   (out_count),
        .out_partial (out_partial),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .miss_count  (miss_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // FIFO model: registered valid one cycle after an accepted read; in
    // stale mode it reports non-empty without holding any data.
    always @(posedge clk) begin
        valid <= 1'b0;
        if (read_enable && fq.size() != 0) begin
            read_data <= fq.pop_front();
            valid     <= 1'b1;
        end
        fifo_empty <= !stale && (fq.size() == 0);
    end

    always @(negedge clk) begin
        beat_t e;
        if (read_enable) re_cnt++;
        if (rst_n && out_valid && out_ready) begin
            beats++;
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", 32'(out_data), 32'(e.data));
                check("beat_count", 32'(out_count), e.cnt);
                check("beat_partial", 32'(out_partial), 32'(e.partial));
            end
        end
    end

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [DW*PW-1:0] d, input int unsigned c, input logic p);
        beat_t b;
        b.data = d; b.cnt = c; b.partial = p;
        exp_q.push_back(b);
    endtask

    task automatic wait_beats(input int unsigned target, input string tag);
        int unsigned n = 0;
        while (beats < target && n < 60) begin
            step(1);
            n++;
        end
        if (beats < target) check(tag, 32'(beats), target);
    endtask

    initial begin
        int unsigned lat;
        int unsigned b0;
        int unsigned r0;
        int unsigned n;

        step(2);
        check("rst_read_enable", 32'(read_enable), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_count", 32'(out_count), 0);
        check("rst_out_partial", 32'(out_partial), 0);
        check("rst_miss_count", 32'(miss_count), 0);
        rst_n = 1'b1;
        step(2);

        // Full beat, minimum latency.
        fq.push_back(12'h123);
        fq.push_back(12'hABC);
        push_exp(24'hABC123, 2, 1'b0);
        step(1);
        r0 = re_cnt;
        out_ready = 1'b1;
        enable = 1'b1;
        lat = 0;
        while (!out_valid && lat < 20) begin
            step(1);
            lat++;
        end
        check("full_latency", lat, 6);
        step(1);
        check("full_valid_one_cycle", 32'(out_valid), 0);
        check("full_reads", re_cnt - r0, 2);
        check("full_beats", beats, 1);
        check("full_miss", 32'(miss_count), 0);

        // Partial beat by flush, then an ignored flush with nothing buffered.
        fq.push_back(12'h5A5);
        push_exp(24'h0005A5, 1, 1'b1);
        step(8);
        check("pre_flush_idle", 32'(out_valid), 0);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        check("flush_valid", 32'(out_valid), 1);
        wait_beats(2, "flush_timeout");
        step(1);
        flush = 1'b1;
        step(4);
        flush = 1'b0;
        check("empty_flush_beats", beats, 2);
        check("empty_flush_valid", 32'(out_valid), 0);

        // Backpressure: beat held, no reads while waiting.
        out_ready = 1'b0;
        fq.push_back(12'h111);
        fq.push_back(12'h222);
        push_exp(24'h222111, 2, 1'b0);
        n = 0;
        while (!out_valid && n < 30) begin
            step(1);
            n++;
        end
        check("bp_reached", 32'(out_valid), 1);
        fq.push_back(12'h333);
        r0 = re_cnt;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("bp_hold_valid", 32'(out_valid), 1);
            check("bp_hold_data", 32'(out_data), 32'h222111);
        end
        check("bp_no_read", re_cnt - r0, 0);
        enable = 1'b0;
        out_ready = 1'b1;
        step(1);
        check("bp_release", 32'(out_valid), 0);
        check("bp_beats", beats, 3);

        // Enable gating with a non-empty FIFO.
        r0 = re_cnt;
        step(5);
        check("gated_no_read", re_cnt - r0, 0);
        push_exp(24'h444333, 2, 1'b0);
        enable = 1'b1;
        check("en_idle_sample", 32'(read_enable), 0);
        step(1);
        check("en_first_read", 32'(read_enable), 1);
        fq.push_back(12'h444);
        wait_beats(4, "en_timeout");

        // Misses: one word buffered, then a stale non-empty flag.
        fq.push_back(12'h0F0);
        step(6);
        b0 = beats;
        stale = 1'b1;
        r0 = re_cnt;
        n = 0;
        while (re_cnt - r0 < 300 && n < 1200) begin
            step(1);
            n++;
        end
        check("miss_reads", re_cnt - r0 >= 300, 1);
        enable = 1'b0;
        step(4);
        stale = 1'b0;
        step(2);
        check("miss_saturated", 32'(miss_count), 255);
        check("miss_no_beat", beats, b0);
        check("miss_no_valid", 32'(out_valid), 0);
        push_exp(24'hE0F0F0, 2, 1'b0);
        fq.push_back(12'hE0F);
        enable = 1'b1;
        wait_beats(b0 + 1, "miss_resume_timeout");
        check("miss_hold", 32'(miss_count), 255);

        // Async reset while waiting on the second word.
        fq.push_back(12'h777);
        step(6);
        fq.push_back(12'h888);
        n = 0;
        while (!read_enable && n < 10) begin
            step(1);
            n++;
        end
        check("rst_reached_req", 32'(read_enable), 1);
        step(1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_read_enable", 32'(read_enable), 0);
        check("arst_out_valid", 32'(out_valid), 0);
        check("arst_out_data", 32'(out_data), 0);
        check("arst_out_count", 32'(out_count), 0);
        check("arst_miss_count", 32'(miss_count), 0);
        step(2);
        rst_n = 1'b1;
        b0 = beats;
        push_exp(24'hBBBAAA, 2, 1'b0);
        fq.push_back(12'hAAA);
        fq.push_back(12'hBBB);
        wait_beats(b0 + 1, "post_rst_timeout");
        step(3);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
